// File: rtl/d_hazard_ctrl_pkg.sv
// Shared constants for the decode-stage hazard controller: forwarding
// select codes and register-file constants.
package d_hazard_ctrl_pkg;

  localparam int          GPR_W     = 5;
  localparam logic [4:0]  GPR_ZERO  = 5'd0;
  localparam int          NUM_SRC   = 2;

  typedef enum logic [1:0] {
    FWD_GPR = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/d_hazard_fwd_sel.sv
// Per-operand hazard detection and forwarding select against the E/M/W
// scoreboard. Purely combinational; instantiated once per source operand.
module d_hazard_fwd_sel
  import d_hazard_ctrl_pkg::*;
#(
  parameter int TNEW_W = 2
) (
  input  logic [GPR_W-1:0]  i_src,
  input  logic [TNEW_W-1:0] i_tuse,
  input  logic [GPR_W-1:0]  i_E_dst,
  input  logic [TNEW_W-1:0] i_E_tnew,
  input  logic [GPR_W-1:0]  i_M_dst,
  input  logic [TNEW_W-1:0] i_M_tnew,
  input  logic [GPR_W-1:0]  i_W_dst,
  output logic              o_stall,
  output fwd_sel_e          o_fwd
);

  logic e_hit;
  logic m_hit;
  logic w_hit;

  assign e_hit = (i_src != GPR_ZERO) && (i_E_dst == i_src);
  assign m_hit = (i_src != GPR_ZERO) && (i_M_dst == i_src);
  assign w_hit = (i_src != GPR_ZERO) && (i_W_dst == i_src);

  always_comb begin
    o_stall = 1'b0;
    o_fwd   = FWD_GPR;
    // Only the youngest producer of the register decides the stall.
    if (e_hit) begin
      o_stall = (i_tuse < i_E_tnew);
    end else if (m_hit) begin
      o_stall = (i_tuse < i_M_tnew);
    end
    if (e_hit && (i_E_tnew == '0)) begin
      o_fwd = FWD_E;
    end else if (m_hit && (i_M_tnew == '0)) begin
      o_fwd = FWD_M;
    end else if (w_hit) begin
      o_fwd = FWD_W;
    end
  end

endmodule

// File: rtl/d_hazard_ctrl.sv
// Decode-stage hazard/issue controller: E/M/W write scoreboard, F/D freeze,
// MDU start pulse and D-stage forwarding selects.
module d_hazard_ctrl
  import d_hazard_ctrl_pkg::*;
#(
  parameter int TNEW_W = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [4:0]        i_D_rs,
  input  logic [4:0]        i_D_rt,
  input  logic [TNEW_W-1:0] i_D_tuseRs,
  input  logic [TNEW_W-1:0] i_D_tuseRt,
  input  logic [4:0]        i_D_dst,
  input  logic [TNEW_W-1:0] i_D_tnew,
  input  logic              i_D_isMdu,
  input  logic              i_D_isMduStart,
  input  logic              i_mdu_busy,
  output logic              o_stall,
  output logic              o_E_start,
  output logic [1:0]        o_D_fwdRs,
  output logic [1:0]        o_D_fwdRt
);

  logic [GPR_W-1:0]  e_dst_q, e_dst_d;
  logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
  logic [GPR_W-1:0]  m_dst_q, m_dst_d;
  logic [TNEW_W-1:0] m_tnew_q, m_tnew_d;
  logic [GPR_W-1:0]  w_dst_q, w_dst_d;
  logic              start_q, start_d;

  logic [GPR_W-1:0]  src_reg  [NUM_SRC];
  logic [TNEW_W-1:0] src_tuse [NUM_SRC];
  logic [NUM_SRC-1:0] src_stall;
  fwd_sel_e          src_fwd  [NUM_SRC];
  logic              mdu_hazard;

  assign src_reg[0]  = i_D_rs;
  assign src_reg[1]  = i_D_rt;
  assign src_tuse[0] = i_D_tuseRs;
  assign src_tuse[1] = i_D_tuseRt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      d_hazard_fwd_sel #(
        .TNEW_W (TNEW_W)
      ) u_fwd_sel (
        .i_src    (src_reg[gi]),
        .i_tuse   (src_tuse[gi]),
        .i_E_dst  (e_dst_q),
        .i_E_tnew (e_tnew_q),
        .i_M_dst  (m_dst_q),
        .i_M_tnew (m_tnew_q),
        .i_W_dst  (w_dst_q),
        .o_stall  (src_stall[gi]),
        .o_fwd    (src_fwd[gi])
      );
    end
  endgenerate

  // start_q covers the cycle before the MDU has raised busy.
  assign mdu_hazard = i_D_isMdu & (i_mdu_busy | start_q);
  assign o_stall    = (|src_stall) | mdu_hazard;
  assign o_E_start  = start_q;
  assign o_D_fwdRs  = src_fwd[0];
  assign o_D_fwdRt  = src_fwd[1];

  always_comb begin
    e_dst_d  = o_stall ? GPR_ZERO : i_D_dst;
    e_tnew_d = o_stall ? '0 : i_D_tnew;
    m_dst_d  = e_dst_q;
    m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - TNEW_W'(1);
    w_dst_d  = m_dst_q;
    start_d  = i_D_isMduStart & ~o_stall;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      e_dst_q  <= GPR_ZERO;
      e_tnew_q <= '0;
      m_dst_q  <= GPR_ZERO;
      m_tnew_q <= '0;
      w_dst_q  <= GPR_ZERO;
      start_q  <= 1'b0;
    end else begin
      e_dst_q  <= e_dst_d;
      e_tnew_q <= e_tnew_d;
      m_dst_q  <= m_dst_d;
      m_tnew_q <= m_tnew_d;
      w_dst_q  <= w_dst_d;
      start_q  <= start_d;
    end
  end

endmodule

// File: tb/tb_d_hazard_ctrl.sv
// Table-driven bench for d_hazard_ctrl plus hand sequences for the
// asynchronous-reset corner cases.
module tb_d_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] tuse_rs, tuse_rt, d_tnew;
  logic       is_mdu, is_start, busy;
  logic       stall, e_start;
  logic [1:0] fwd_rs, fwd_rt;

  int checks = 0;
  int errors = 0;

  d_hazard_ctrl #(.TNEW_W(2)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_D_rs         (d_rs),
    .i_D_rt         (d_rt),
    .i_D_tuseRs     (tuse_rs),
    .i_D_tuseRt     (tuse_rt),
    .i_D_dst        (d_dst),
    .i_D_tnew       (d_tnew),
    .i_D_isMdu      (is_mdu),
    .i_D_isMduStart (is_start),
    .i_mdu_busy     (busy),
    .o_stall        (stall),
    .o_E_start      (e_start),
    .o_D_fwdRs      (fwd_rs),
    .o_D_fwdRt      (fwd_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [1:0] tuse_rs;
    logic [4:0] rt;
    logic [1:0] tuse_rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       is_mdu;
    logic       is_start;
    logic       busy;
    logic       x_stall;
    logic       x_start;
    logic [1:0] x_fwd_rs;
    logic [1:0] x_fwd_rt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [4:0] rs, logic [1:0] trs,
                              logic [4:0] rt, logic [1:0] trt,
                              logic [4:0] dst, logic [1:0] tn,
                              logic m, logic s, logic b,
                              logic xs, logic xst, logic [1:0] xfs, logic [1:0] xft);
    vec_t v;
    v.rst = r; v.rs = rs; v.tuse_rs = trs; v.rt = rt; v.tuse_rt = trt;
    v.dst = dst; v.tnew = tn; v.is_mdu = m; v.is_start = s; v.busy = b;
    v.x_stall = xs; v.x_start = xst; v.x_fwd_rs = xfs; v.x_fwd_rt = xft;
    return v;
  endfunction

  task automatic check(string name, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic [4:0] rs, logic [1:0] trs, logic [4:0] rt, logic [1:0] trt,
                       logic [4:0] dst, logic [1:0] tn, logic m, logic s, logic b);
    d_rs = rs; tuse_rs = trs; d_rt = rt; tuse_rt = trt;
    d_dst = dst; d_tnew = tn; is_mdu = m; is_start = s; busy = b;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 3, 0, 3, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //           rst rs tr rt tr dst tn mdu st bsy | stall start frs frt
    vecs.push_back(mk(1, 0,3, 0,3, 0,0, 0,0,0, 0,0,0,0)); // reset state
    vecs.push_back(mk(0, 0,3, 0,3, 5,2, 0,0,0, 0,0,0,0)); // lw $5
    vecs.push_back(mk(0, 5,1, 0,3, 9,1, 0,0,0, 1,0,0,0)); // load-use stall
    vecs.push_back(mk(0, 5,1, 0,3, 9,1, 0,0,0, 0,0,0,0)); // released, M={5,1}
    vecs.push_back(mk(0, 5,0, 9,2, 8,0, 0,0,0, 0,0,3,0)); // W fwd rs
    vecs.push_back(mk(0, 8,0, 9,0, 8,0, 0,0,0, 0,0,1,2)); // E fwd rs, M fwd rt
    vecs.push_back(mk(0, 8,0, 9,0, 0,0, 0,0,0, 0,0,1,3)); // E beats M, W fwd rt
    vecs.push_back(mk(0, 8,0, 8,1, 0,2, 0,0,0, 0,0,2,2)); // rs=rt from M
    vecs.push_back(mk(0, 0,0, 0,0, 7,3, 0,0,0, 0,0,0,0)); // $0 vs E={0,2}
    vecs.push_back(mk(0, 7,2, 7,3, 0,0, 0,0,0, 1,0,0,0)); // rs stalls, rt not
    vecs.push_back(mk(0, 7,2, 7,3, 0,0, 0,0,0, 0,0,0,0)); // M={7,2} no stall
    vecs.push_back(mk(0, 7,0, 0,3, 0,0, 1,1,0, 0,0,3,0)); // mult issue
    vecs.push_back(mk(0, 0,3, 0,3, 3,1, 1,0,0, 1,1,0,0)); // mflo, start in E
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0,3, 0,3, 3,1, 1,0,1, 1,0,0,0)); // busy
    vecs.push_back(mk(0, 0,3, 0,3, 3,1, 1,0,0, 0,0,0,0)); // mflo goes
    vecs.push_back(mk(0, 0,3, 0,3, 0,0, 1,0,1, 1,0,0,0)); // mthi behind div
    vecs.push_back(mk(0, 0,3, 0,3, 0,0, 1,0,0, 0,0,0,0)); // released
    vecs.push_back(mk(0, 0,3, 0,3, 0,0, 0,0,0, 0,0,0,0)); // no start

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].rst) begin
        rst = 1'b1;
        #1 rst = 1'b0;
      end
      drive(vecs[i].rs, vecs[i].tuse_rs, vecs[i].rt, vecs[i].tuse_rt,
            vecs[i].dst, vecs[i].tnew, vecs[i].is_mdu, vecs[i].is_start, vecs[i].busy);
      #1;
      check($sformatf("v%0d_stall", i), {1'b0, stall}, {1'b0, vecs[i].x_stall});
      check($sformatf("v%0d_start", i), {1'b0, e_start}, {1'b0, vecs[i].x_start});
      check($sformatf("v%0d_fwdRs", i), fwd_rs, vecs[i].x_fwd_rs);
      check($sformatf("v%0d_fwdRt", i), fwd_rt, vecs[i].x_fwd_rt);
      $display("vec %0d: stall=%0d start=%0d fwdRs=%0d fwdRt=%0d", i, stall, e_start, fwd_rs, fwd_rt);
    end

    // Reset asserted mid-stall clears stall and start without a clock edge.
    @(negedge clk);
    drive(0, 3, 0, 3, 5, 2, 1, 1, 0);      // mult writing $5, tnew 2
    @(negedge clk);
    drive(5, 1, 0, 3, 0, 0, 0, 0, 0);      // load-use on $5
    #1;
    check("seq_start_before_rst", {1'b0, e_start}, 2'd1);
    check("seq_stall_before_rst", {1'b0, stall}, 2'd1);
    rst = 1'b1;
    #1;
    check("seq_stall_in_rst", {1'b0, stall}, 2'd0);
    check("seq_start_in_rst", {1'b0, e_start}, 2'd0);
    check("seq_fwdRs_in_rst", fwd_rs, 2'd0);
    $display("seq async reset: stall=%0d start=%0d fwdRs=%0d", stall, e_start, fwd_rs);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    check("seq_stall_after_rst", {1'b0, stall}, 2'd0);
    $display("seq after reset: stall=%0d", stall);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
